// File: rtl/multi_freq_synth_core.sv
// Time-multiplexed bank of NCH coupled-form resonators (rotate-and-add oscillators) with a summed output.
// Latency: out_valid pulses NCH+1 clocks after the edge that accepts sample_en.
// Backpressure: none; sample_en while busy is dropped and latches the sticky overrun flag.
module multi_freq_synth_core #(
    parameter int  DW  = 10,
    parameter int  CW  = 16,
    parameter int  NCH = 4,
    localparam int CHW = $clog2(NCH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sample_en,
    input  logic                  ctrl,
    input  logic signed [DW-1:0]  in_data,
    input  logic [NCH-1:0]        ch_en,
    input  logic                  cfg_we,
    input  logic [CHW-1:0]        cfg_ch,
    input  logic signed [CW-1:0]  cfg_cos,
    input  logic signed [CW-1:0]  cfg_sin,
    input  logic signed [DW-1:0]  cfg_i0,
    input  logic signed [DW-1:0]  cfg_q0,
    input  logic [CHW-1:0]        mon_ch,
    output logic signed [DW-1:0]  out_data,
    output logic                  out_valid,
    output logic signed [DW-1:0]  I,
    output logic signed [DW-1:0]  Q,
    output logic                  busy,
    output logic                  overrun
);

    // Wide working width: holds a full-precision product sum plus the drive term
    localparam int AW = DW + CW + 1;
    localparam int SW = DW + CHW + 1;

    localparam logic signed [AW-1:0] RND     = AW'(2 ** (CW - 3));
    localparam logic signed [AW-1:0] SAT_MAX = AW'(2 ** (DW - 1) - 1);
    localparam logic signed [AW-1:0] SAT_MIN = AW'(-(2 ** (DW - 1)));

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Clamp a wide signed value into the DW-bit sample range
    function automatic logic signed [DW-1:0] sat_dw(input logic signed [AW-1:0] v);
        if (v > SAT_MAX) begin
            sat_dw = SAT_MAX[DW-1:0];
        end else if (v < SAT_MIN) begin
            sat_dw = SAT_MIN[DW-1:0];
        end else begin
            sat_dw = v[DW-1:0];
        end
    endfunction

    state_t                 state_q, state_d;
    logic [CHW-1:0]         cnt_q, cnt_d;
    logic signed [SW-1:0]   sum_q, sum_d;
    logic                   ctrl_q, ctrl_d;
    logic signed [DW-1:0]   din_q, din_d;
    logic signed [DW-1:0]   out_data_q, out_data_d;
    logic                   out_valid_q, out_valid_d;
    logic signed [DW-1:0]   i_out_q, i_out_d;
    logic signed [DW-1:0]   q_out_q, q_out_d;
    logic                   busy_q, busy_d;
    logic                   overrun_q, overrun_d;

    logic signed [DW-1:0]   ch_i_q   [NCH];
    logic signed [DW-1:0]   ch_i_d   [NCH];
    logic signed [DW-1:0]   ch_q_q   [NCH];
    logic signed [DW-1:0]   ch_q_d   [NCH];
    logic signed [CW-1:0]   ch_cos_q [NCH];
    logic signed [CW-1:0]   ch_cos_d [NCH];
    logic signed [CW-1:0]   ch_sin_q [NCH];
    logic signed [CW-1:0]   ch_sin_d [NCH];

    logic signed [DW-1:0]    cur_i, cur_q, drive, new_i, new_q;
    logic signed [CW-1:0]    cur_c, cur_s;
    logic signed [AW-2:0]    p_ic, p_qs, p_is, p_qc;
    logic signed [AW-1:0]    acc_i, acc_q, rnd_i, rnd_q;

    // Rotation datapath for the channel selected by cnt
    always_comb begin
        cur_i = ch_i_q[cnt_q];
        cur_q = ch_q_q[cnt_q];
        cur_c = ch_cos_q[cnt_q];
        cur_s = ch_sin_q[cnt_q];
        drive = ctrl_q ? din_q : '0;
        p_ic  = (AW-1)'(cur_i) * (AW-1)'(cur_c);
        p_qs  = (AW-1)'(cur_q) * (AW-1)'(cur_s);
        p_is  = (AW-1)'(cur_i) * (AW-1)'(cur_s);
        p_qc  = (AW-1)'(cur_q) * (AW-1)'(cur_c);
        acc_i = AW'(p_ic) - AW'(p_qs);
        acc_q = AW'(p_is) + AW'(p_qc);
        // Round half up, then drop the Q1.(CW-2) fractional bits
        rnd_i = (acc_i + RND) >>> (CW - 2);
        rnd_q = (acc_q + RND) >>> (CW - 2);
        new_i = sat_dw(rnd_i + AW'(drive));
        new_q = sat_dw(rnd_q);
    end

    // Next-state logic: sequencer, accumulator, output registers, channel bank
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        sum_d       = sum_q;
        ctrl_d      = ctrl_q;
        din_d       = din_q;
        out_data_d  = out_data_q;
        out_valid_d = 1'b0;
        i_out_d     = i_out_q;
        q_out_d     = q_out_q;
        busy_d      = busy_q;
        overrun_d   = overrun_q;
        ch_i_d      = ch_i_q;
        ch_q_d      = ch_q_q;
        ch_cos_d    = ch_cos_q;
        ch_sin_d    = ch_sin_q;

        case (state_q)
            IDLE: begin
                if (sample_en) begin
                    state_d = RUN;
                    cnt_d   = '0;
                    sum_d   = '0;
                    ctrl_d  = ctrl;
                    din_d   = in_data;
                    busy_d  = 1'b1;
                end
            end
            RUN: begin
                // Output tracks the pre-update I of every enabled channel
                if (ch_en[cnt_q]) begin
                    sum_d = sum_q + SW'(cur_i);
                end
                ch_i_d[cnt_q] = new_i;
                ch_q_d[cnt_q] = new_q;
                if (cnt_q == CHW'(NCH - 1)) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CHW'(1);
                end
            end
            DONE: begin
                state_d     = IDLE;
                busy_d      = 1'b0;
                out_valid_d = 1'b1;
                out_data_d  = sat_dw(AW'(sum_q));
                i_out_d     = ch_i_q[mon_ch];
                q_out_d     = ch_q_q[mon_ch];
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase

        if (sample_en && busy_q) begin
            overrun_d = 1'b1;
        end

        // Host writes land last so they override a same-cycle rotation update
        if (cfg_we) begin
            ch_i_d[cfg_ch]   = cfg_i0;
            ch_q_d[cfg_ch]   = cfg_q0;
            ch_cos_d[cfg_ch] = cfg_cos;
            ch_sin_d[cfg_ch] = cfg_sin;
        end
    end

    // State registers with asynchronous clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            sum_q       <= '0;
            ctrl_q      <= 1'b0;
            din_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            i_out_q     <= '0;
            q_out_q     <= '0;
            busy_q      <= 1'b0;
            overrun_q   <= 1'b0;
            for (int k = 0; k < NCH; k++) begin
                ch_i_q[k]   <= '0;
                ch_q_q[k]   <= '0;
                ch_cos_q[k] <= '0;
                ch_sin_q[k] <= '0;
            end
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sum_q       <= sum_d;
            ctrl_q      <= ctrl_d;
            din_q       <= din_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            i_out_q     <= i_out_d;
            q_out_q     <= q_out_d;
            busy_q      <= busy_d;
            overrun_q   <= overrun_d;
            ch_i_q      <= ch_i_d;
            ch_q_q      <= ch_q_d;
            ch_cos_q    <= ch_cos_d;
            ch_sin_q    <= ch_sin_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign I         = i_out_q;
    assign Q         = q_out_q;
    assign busy      = busy_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_multi_freq_synth_core.sv
// Bench for multi_freq_synth_core: sample-level reference model plus directed scenarios.
// The model computes a whole sample at the accepting edge and releases it NCH+1 clocks later.
// A per-cycle compare process checks every output; directed tasks pin literal values.
module tb_multi_freq_synth_core;

    localparam int DW  = 10;
    localparam int CW  = 16;
    localparam int NCH = 4;

    logic                 clk       = 1'b0;
    logic                 rst       = 1'b0;
    logic                 sample_en = 1'b0;
    logic                 ctrl      = 1'b0;
    logic signed [DW-1:0] in_data   = '0;
    logic [NCH-1:0]       ch_en     = '0;
    logic                 cfg_we    = 1'b0;
    logic [1:0]           cfg_ch    = '0;
    logic signed [CW-1:0] cfg_cos   = '0;
    logic signed [CW-1:0] cfg_sin   = '0;
    logic signed [DW-1:0] cfg_i0    = '0;
    logic signed [DW-1:0] cfg_q0    = '0;
    logic [1:0]           mon_ch    = '0;
    logic signed [DW-1:0] out_data;
    logic                 out_valid;
    logic signed [DW-1:0] I;
    logic signed [DW-1:0] Q;
    logic                 busy;
    logic                 overrun;

    multi_freq_synth_core #(.DW(DW), .CW(CW), .NCH(NCH)) dut (
        .clk       (clk),
        .rst       (rst),
        .sample_en (sample_en),
        .ctrl      (ctrl),
        .in_data   (in_data),
        .ch_en     (ch_en),
        .cfg_we    (cfg_we),
        .cfg_ch    (cfg_ch),
        .cfg_cos   (cfg_cos),
        .cfg_sin   (cfg_sin),
        .cfg_i0    (cfg_i0),
        .cfg_q0    (cfg_q0),
        .mon_ch    (mon_ch),
        .out_data  (out_data),
        .out_valid (out_valid),
        .I         (I),
        .Q         (Q),
        .busy      (busy),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (sample-level arithmetic) ----------------
    function automatic int rnd(input longint x);
        return int'((x + 64'sd8192) >>> 14);
    endfunction

    function automatic int sat(input int x);
        if (x > 511) return 511;
        if (x < -512) return -512;
        return x;
    endfunction

    int m_i [NCH];
    int m_q [NCH];
    int m_c [NCH];
    int m_s [NCH];
    int countdown = 0;
    int pend_out  = 0;
    bit m_busy    = 0;
    bit m_ovr     = 0;
    bit e_valid   = 0;
    int e_out     = 0;
    int e_i       = 0;
    int e_q       = 0;

    always @(posedge clk or posedge rst) begin
        bit busy_pre;
        int d, sum, ni, nq;
        if (rst) begin
            for (int k = 0; k < NCH; k++) begin
                m_i[k] = 0; m_q[k] = 0; m_c[k] = 0; m_s[k] = 0;
            end
            countdown = 0; m_busy = 0; m_ovr = 0; e_valid = 0;
            e_out = 0; e_i = 0; e_q = 0; pend_out = 0;
        end else begin
            busy_pre = m_busy;
            e_valid  = 0;
            if (countdown > 0) begin
                countdown--;
                if (countdown == 0) begin
                    e_valid = 1;
                    e_out   = pend_out;
                    e_i     = m_i[mon_ch];
                    e_q     = m_q[mon_ch];
                    m_busy  = 0;
                end
            end
            if (cfg_we) begin
                m_i[cfg_ch] = int'(cfg_i0);
                m_q[cfg_ch] = int'(cfg_q0);
                m_c[cfg_ch] = int'(cfg_cos);
                m_s[cfg_ch] = int'(cfg_sin);
            end
            if (sample_en) begin
                if (busy_pre) begin
                    m_ovr = 1;
                end else begin
                    d   = ctrl ? int'(in_data) : 0;
                    sum = 0;
                    for (int k = 0; k < NCH; k++) begin
                        if (ch_en[k]) sum += m_i[k];
                        ni = sat(rnd(longint'(m_i[k]) * m_c[k] - longint'(m_q[k]) * m_s[k]) + d);
                        nq = sat(rnd(longint'(m_i[k]) * m_s[k] + longint'(m_q[k]) * m_c[k]));
                        m_i[k] = ni;
                        m_q[k] = nq;
                    end
                    pend_out  = sat(sum);
                    countdown = NCH + 1;
                    m_busy    = 1;
                end
            end
        end
    end

    // Per-cycle comparison against the model, sampled after outputs settle
    always @(posedge clk) begin
        #3;
        chk("out_valid", int'(out_valid), int'(e_valid));
        chk("busy",      int'(busy),      int'(m_busy));
        chk("overrun",   int'(overrun),   int'(m_ovr));
        chk("out_data",  int'(out_data),  e_out);
        chk("I",         int'(I),         e_i);
        chk("Q",         int'(Q),         e_q);
    end

    // ---------------- directed stimulus ----------------
    task automatic cfg(input int ch, input int c, input int s, input int i0, input int q0);
        @(negedge clk);
        cfg_we  = 1'b1;
        cfg_ch  = 2'(ch);
        cfg_cos = 16'(c);
        cfg_sin = 16'(s);
        cfg_i0  = 10'(i0);
        cfg_q0  = 10'(q0);
        @(negedge clk);
        cfg_we  = 1'b0;
    endtask

    task automatic sample_chk(input string name, input int eo, input int ei, input int eq);
        int lat;
        lat = 0;
        @(negedge clk);
        sample_en = 1'b1;
        @(negedge clk);
        sample_en = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #4;
            if (out_valid) begin
                lat = k;
                break;
            end
        end
        chk({name, "_latency"},  lat, 5);
        chk({name, "_out_data"}, int'(out_data), eo);
        chk({name, "_I"},        int'(I), ei);
        chk({name, "_Q"},        int'(Q), eq);
    endtask

    task automatic count_valids(input int cycles, output int n);
        n = 0;
        for (int k = 0; k < cycles; k++) begin
            @(posedge clk);
            #4;
            if (out_valid) n++;
        end
    endtask

    initial begin
        int nv;
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_out_data",  int'(out_data),  0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_busy",      int'(busy),      0);
        chk("rst_overrun",   int'(overrun),   0);

        // Identity rotation holds the state
        mon_ch = 2'd0;
        ch_en  = 4'b0001;
        cfg(0, 16384, 0, 100, 0);
        sample_chk("ident1", 100, 100, 0);
        sample_chk("ident2", 100, 100, 0);

        // Quarter-turn rotation walks around the circle
        cfg(0, 0, 16384, 100, 0);
        sample_chk("rot1", 100, 0, 100);
        sample_chk("rot2", 0, -100, 0);
        sample_chk("rot3", -100, 0, -100);
        sample_chk("rot4", 0, 100, 0);

        // Output sum clamps at both rails
        for (int k = 0; k < NCH; k++) cfg(k, 16384, 0, 400, 0);
        ch_en = 4'b1111;
        sample_chk("sat_pos", 511, 400, 0);
        for (int k = 0; k < NCH; k++) cfg(k, 16384, 0, -400, 0);
        sample_chk("sat_neg", -512, -400, 0);

        // Driven mode injects in_data into I
        for (int k = 0; k < NCH; k++) cfg(k, 0, 0, 0, 0);
        ch_en   = 4'b0001;
        ctrl    = 1'b1;
        in_data = 10'sd37;
        sample_chk("drv1", 0, 37, 0);
        sample_chk("drv2", 37, 37, 0);
        ctrl    = 1'b0;
        in_data = '0;

        // Back-to-back sample_en: one result, sticky overrun
        chk("ovr_pre", int'(overrun), 0);
        cfg(0, 16384, 0, 20, 0);
        @(negedge clk);
        sample_en = 1'b1;
        @(negedge clk);
        @(negedge clk);
        sample_en = 1'b0;
        count_valids(12, nv);
        chk("ovr_valid_count", nv, 1);
        chk("ovr_flag", int'(overrun), 1);
        sample_chk("ovr_after", 20, 20, 0);
        chk("ovr_sticky", int'(overrun), 1);

        // Reset in the middle of a sample aborts it
        cfg(0, 16384, 0, 100, 0);
        @(negedge clk);
        sample_en = 1'b1;
        @(negedge clk);
        sample_en = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_busy",     int'(busy),     0);
        chk("midrst_overrun",  int'(overrun),  0);
        chk("midrst_out_data", int'(out_data), 0);
        chk("midrst_I",        int'(I),        0);
        chk("midrst_Q",        int'(Q),        0);
        @(negedge clk);
        rst = 1'b0;
        count_valids(8, nv);
        chk("midrst_no_valid", nv, 0);
        cfg(0, 16384, 0, 55, 0);
        sample_chk("post_rst", 55, 55, 0);

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
